// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one line-wide memory port between the
// instruction cache (ic) and data cache (dc) of the RV32I core.
// One line transaction is granted at a time. The command is registered
// onto the shared port, and the response is steered back to the winner.
// Optional macro CACHE_ARB_RR_EN: round-robin arbitration on ties.
// Without this macro, dc has fixed priority over ic.
module cache_mem_arbiter #(
  parameter int unsigned ADDR_W = 26,
  parameter int unsigned DATA_W = 128,
  parameter int unsigned BE_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] i_ic_addr,
  input  logic [BE_W-1:0]   i_ic_byte_en,
  input  logic [DATA_W-1:0] i_ic_writedata,
  input  logic              i_ic_read,
  input  logic              i_ic_write,
  output logic [DATA_W-1:0] o_ic_readdata,
  output logic              o_ic_readdata_valid,
  output logic              o_ic_waitrequest,
  input  logic [ADDR_W-1:0] i_dc_addr,
  input  logic [BE_W-1:0]   i_dc_byte_en,
  input  logic [DATA_W-1:0] i_dc_writedata,
  input  logic              i_dc_read,
  input  logic              i_dc_write,
  output logic [DATA_W-1:0] o_dc_readdata,
  output logic              o_dc_readdata_valid,
  output logic              o_dc_waitrequest,
  output logic [ADDR_W-1:0] o_m_addr,
  output logic [BE_W-1:0]   o_m_byte_en,
  output logic [DATA_W-1:0] o_m_writedata,
  output logic              o_m_read,
  output logic              o_m_write,
  input  logic [DATA_W-1:0] i_m_readdata,
  input  logic              i_m_readdata_valid,
  input  logic              i_m_waitrequest,
  output logic [1:0]        o_grant
);

  typedef enum logic [1:0] {IDLE, RD, WR} state_t;

  state_t state;
  logic   ic_req;
  logic   dc_req;
  logic   pick_dc;
  logic   win_write;
  logic   rd_done;
  logic   wr_done;

`ifdef CACHE_ARB_RR_EN
  // Slot granted most recently; on a tie, the other slot wins.
  logic   last_dc;
`endif

  assign ic_req = i_ic_read | i_ic_write;
  assign dc_req = i_dc_read | i_dc_write;

  // Winner selection for the next grant, and its command type (write beats read)
  always_comb begin
    pick_dc = 1'b0;
`ifdef CACHE_ARB_RR_EN
    pick_dc = dc_req & (~ic_req | ~last_dc);
`else
    pick_dc = dc_req;
`endif
    win_write = pick_dc ? i_dc_write : i_ic_write;
  end

  // Grant FSM; the shared-port command and the owner are registered here
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      o_m_addr      <= '0;
      o_m_byte_en   <= '0;
      o_m_writedata <= '0;
      o_m_read      <= 1'b0;
      o_m_write     <= 1'b0;
      o_grant       <= '0;
`ifdef CACHE_ARB_RR_EN
      last_dc       <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ic_req | dc_req) begin
            o_m_addr      <= pick_dc ? i_dc_addr      : i_ic_addr;
            o_m_byte_en   <= pick_dc ? i_dc_byte_en   : i_ic_byte_en;
            o_m_writedata <= pick_dc ? i_dc_writedata : i_ic_writedata;
            o_grant       <= pick_dc ? 2'b10 : 2'b01;
`ifdef CACHE_ARB_RR_EN
            last_dc       <= pick_dc;
`endif
            if (win_write) begin
              o_m_write <= 1'b1;
              state     <= WR;
            end else begin
              o_m_read  <= 1'b1;
              state     <= RD;
            end
          end
        end
        RD: begin
          if (i_m_readdata_valid) begin
            o_m_read <= 1'b0;
            o_grant  <= '0;
            state    <= IDLE;
          end
        end
        WR: begin
          if (!i_m_waitrequest) begin
            o_m_write <= 1'b0;
            o_grant   <= '0;
            state     <= IDLE;
          end
        end
        default: begin
          o_m_read  <= 1'b0;
          o_m_write <= 1'b0;
          o_grant   <= '0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // Completion is signalled in the same cycle that the memory responds. A stray
  // readdata_valid outside RD is never forwarded.
  always_comb begin
    rd_done             = (state == RD) & i_m_readdata_valid;
    wr_done             = (state == WR) & o_m_write & ~i_m_waitrequest;
    o_ic_readdata_valid = rd_done & o_grant[0];
    o_dc_readdata_valid = rd_done & o_grant[1];
    o_ic_waitrequest    = ~((rd_done | wr_done) & o_grant[0]);
    o_dc_waitrequest    = ~((rd_done | wr_done) & o_grant[1]);
    o_ic_readdata       = o_ic_readdata_valid ? i_m_readdata : '0;
    o_dc_readdata       = o_dc_readdata_valid ? i_m_readdata : '0;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares one 128-bit line-wide memory port between the instruction cache and the data cache of the RV32I core.
- Each cache connects its memory-side master interface (addr/byte_en/writedata/read/write in; readdata/readdata_valid/waitrequest out) to one requester slot.
- The arbiter grants one line transaction at a time, registers the command onto the shared port, and steers the response back to the winner.

Parameters:
- ADDR_W, 26, line address width (matches cache o_m_addr).
- DATA_W, 128, line data width.
- BE_W, 4, byte-enable width passed through unchanged.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- i_ic_addr / i_dc_addr  in  ADDR_W  requester line address.
- i_ic_byte_en / i_dc_byte_en  in  BE_W  requester byte enable.
- i_ic_writedata / i_dc_writedata  in  DATA_W  requester write line.
- i_ic_read / i_dc_read  in  1  read request, level, held until completion.
- i_ic_write / i_dc_write  in  1  write request, level, held until completion.
- o_ic_readdata / o_dc_readdata  out  DATA_W  returned line.
- o_ic_readdata_valid / o_dc_readdata_valid  out  1  one-cycle read-completion pulse.
- o_ic_waitrequest / o_dc_waitrequest  out  1  low only in that requester's completion cycle.
- o_m_addr, o_m_byte_en, o_m_writedata  out  ADDR_W/BE_W/DATA_W  shared-port command.
- o_m_read, o_m_write  out  1  shared-port strobes.
- i_m_readdata  in  DATA_W; i_m_readdata_valid  in  1; i_m_waitrequest  in  1  shared-port response.
- o_grant  out  2  one-hot current owner, {dc, ic}; 2'b00 when idle.

Behaviour:
- Reset values:
  - o_m_read=0, o_m_write=0, o_m_addr=0, o_m_byte_en=0, o_m_writedata=0.
  - o_grant=0.
  - Both waitrequest=1, both readdata_valid=0, both readdata=0.
  - State=IDLE; round-robin pointer = ic.
- States: IDLE, RD, WR.
- IDLE: at a clock edge with any request pending:
  - Select the winner; register its addr/byte_en/writedata onto o_m_*.
  - Set o_grant; set o_m_read or o_m_write; go to RD or WR.
  - Command appears on the shared port 1 cycle after the request is first sampled.
  - No request: stay in IDLE, strobes stay 0.
- Requester with read and write both set: write taken, read ignored for that grant.
- RD:
  - o_m_read held and command held stable until i_m_readdata_valid=1.
  - In that cycle, combinationally: winner readdata = i_m_readdata, winner readdata_valid=1, winner waitrequest=0.
  - Next edge: o_m_read=0, o_grant=0, state→IDLE.
  - i_m_waitrequest is ignored in RD.
- WR:
  - o_m_write held until a cycle with o_m_write=1 and i_m_waitrequest=0.
  - In that cycle, winner waitrequest=0 (combinational).
  - Next edge: o_m_write=0, o_grant=0, state→IDLE.
- Non-winner: waitrequest=1, readdata_valid=0 at all times.
- Back-to-back: each completion returns to IDLE for one cycle; the next grant issues on the following edge. Minimum 3 cycles per transaction with a 1-cycle-latency memory.
- Fixed priority (macro absent): dc beats ic on simultaneous requests.
- A requester dropping its request mid-grant is illegal. The arbiter still completes the transaction and delivers the pulse; the bench must flag the drop.
- Stray i_m_readdata_valid in IDLE or WR: ignored, not forwarded.
- rst asserted mid-transaction: all outputs return to reset values at that edge. An in-flight memory response arriving after reset is dropped.
- No data width conversion; all fields pass through bit-exact.

Optional Feature:
- Macro: CACHE_ARB_RR_EN.
- Defined:
  - Round-robin arbitration. On a simultaneous request, the slot not granted last wins.
  - Pointer updates at each grant to the granted slot; resets to ic (so dc wins the first tie).
  - A single requester is granted every time regardless of the pointer.
- Undefined: fixed dc-over-ic priority; the pointer logic is absent.

Test Plan:
- Reset, then ic read addr 26'h0000010; memory returns 128'hA5…A5 one cycle after o_m_read.
  → o_m_addr=26'h10; o_ic_readdata_valid pulses once with 128'hA5…A5; o_grant 2'b01→2'b00; o_dc_waitrequest stays 1.
- dc write addr 26'h3F, byte_en 4'hF, data 128'h1234; memory holds i_m_waitrequest=1 for 3 cycles, then 0.
  → o_m_write high 4 cycles with stable addr/data; o_dc_waitrequest=0 only in the final cycle.
- ic read and dc read raised on the same edge, macro undefined → dc served first, ic granted immediately after. Repeat the tie → dc first again.
- Same tie stimulus, CACHE_ARB_RR_EN defined, three consecutive ties → grant order dc, ic, dc, ic, dc, ic.
- rst pulsed while in RD before readdata_valid; the late i_m_readdata_valid arrives after reset → no readdata_valid on either requester; o_m_read=0 from the reset edge.
- dc asserts read and write together on addr 26'h5 → write issued (o_m_write=1, o_m_read=0) and completes normally.
